// File: rtl/gb_video_pkg.sv
// Shared types for the bitmap display's producer side.
//   SCREEN_W / SCREEN_H : default frame geometry in pixels.
//   gb_color_t          : 2-bit pixel color.
//   pix_entry_t         : one buffered stream pixel (start-of-frame flag + color).
//   writer_state_t      : writer FSM states (WRITE = streaming, SWAP = waiting for ack).
package gb_video_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [1:0] gb_color_t;

  typedef struct packed {
    logic      sof;
    gb_color_t color;
  } pix_entry_t;

  typedef enum logic {
    WRITE = 1'b0,
    SWAP  = 1'b1
  } writer_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding stream pixels between the renderer and the writer.
// Ports:
//   clk, reset          : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data     : write request/data; ignored while full, even if popping
//   pop, pop_data       : read request; pop_data shows the head entry while not empty
//   full, empty         : occupancy flags
module pixel_fifo
  import gb_video_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = pix_entry_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  // No full-bypass: a full FIFO refuses the push even when a pop frees a slot.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/frame_pixel_writer.sv
// Producer side of the double-buffered bitmap display. Buffers a raster-order pixel
// stream and turns it into registered back-buffer writes, then requests a buffer swap
// after the last pixel of each frame and stalls the stream until it is acknowledged.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   pix_valid/pix_ready/pix_color/pix_sof : input pixel stream (valid/ready)
//   x, y, color, wr_en                : registered back-buffer write
//   swapBuffer, bufferSwapped         : swap request / one-cycle acknowledge
//   frame_done                        : pulse the cycle after the ack is taken
//   sync_err                          : pulse alongside a write resynchronised by SOF
//   frame_count                       : swapped frames, modulo 256
module frame_pixel_writer
  import gb_video_pkg::*;
#(
  parameter int WIDTH      = SCREEN_W,
  parameter int HEIGHT     = SCREEN_H,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [1:0] pix_color,
  input  logic       pix_sof,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [1:0] color,
  output logic       wr_en,
  output logic       swapBuffer,
  input  logic       bufferSwapped,
  output logic       frame_done,
  output logic       sync_err,
  output logic [7:0] frame_count
);

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

  writer_state_t state_q, state_d;
  logic [7:0]    cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [7:0]    x_q, x_d, y_q, y_d, frame_count_q, frame_count_d;
  gb_color_t     color_q, color_d;
  logic          wr_en_q, wr_en_d, frame_done_q, frame_done_d, sync_err_q, sync_err_d;

  pix_entry_t    push_entry, head;
  logic          fifo_full, fifo_empty, pop, resync;
  logic [7:0]    wr_x, wr_y;

  assign push_entry = '{sof: pix_sof, color: pix_color};
  assign pix_ready  = !fifo_full;
  assign pop        = (state_q == WRITE) && !fifo_empty;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (pix_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pix_valid),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A SOF pixel away from the origin restarts the frame: it is written at (0,0)
  // and the counters advance from there as for any pixel at the origin.
  assign resync = pop && head.sof && ((cur_x_q != 8'd0) || (cur_y_q != 8'd0));
  assign wr_x   = resync ? 8'd0 : cur_x_q;
  assign wr_y   = resync ? 8'd0 : cur_y_q;

  always_comb begin
    state_d       = state_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    x_d           = x_q;
    y_d           = y_q;
    color_d       = color_q;
    frame_count_d = frame_count_q;
    wr_en_d       = 1'b0;
    frame_done_d  = 1'b0;
    sync_err_d    = 1'b0;
    case (state_q)
      WRITE: begin
        if (pop) begin
          wr_en_d    = 1'b1;
          x_d        = wr_x;
          y_d        = wr_y;
          color_d    = head.color;
          sync_err_d = resync;
          if (wr_x == X_LAST) begin
            cur_x_d = 8'd0;
            if (wr_y == Y_LAST) begin
              cur_y_d = 8'd0;
              state_d = SWAP;
            end else begin
              cur_y_d = wr_y + 8'd1;
            end
          end else begin
            cur_x_d = wr_x + 8'd1;
            cur_y_d = wr_y;
          end
        end
      end
      SWAP: begin
        // Leaving on the first ack cycle makes a long ack count as one swap.
        if (bufferSwapped) begin
          state_d       = WRITE;
          frame_count_d = frame_count_q + 8'd1;
          frame_done_d  = 1'b1;
        end
      end
      default: state_d = WRITE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WRITE;
      cur_x_q       <= 8'd0;
      cur_y_q       <= 8'd0;
      x_q           <= 8'd0;
      y_q           <= 8'd0;
      color_q       <= 2'd0;
      wr_en_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      sync_err_q    <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      x_q           <= x_d;
      y_q           <= y_d;
      color_q       <= color_d;
      wr_en_q       <= wr_en_d;
      frame_done_q  <= frame_done_d;
      sync_err_q    <= sync_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign color       = color_q;
  assign wr_en       = wr_en_q;
  assign frame_done  = frame_done_q;
  assign sync_err    = sync_err_q;
  assign frame_count = frame_count_q;
  assign swapBuffer  = (state_q == SWAP);

endmodule

// File: tb/tb_frame_pixel_writer.sv
// Scoreboard bench for frame_pixel_writer. A reduced 40x4 frame keeps the
// frame_count wrap run (254+ frames) inside a short simulation.
module tb_frame_pixel_writer;

  localparam int W = 40;
  localparam int H = 4;
  localparam int D = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic [1:0] pix_color = 2'd0;
  logic       bufferSwapped = 1'b0;
  logic       pix_ready, wr_en, swapBuffer, frame_done, sync_err;
  logic [7:0] x, y, frame_count;
  logic [1:0] color;

  always #5 clk = ~clk;

  frame_pixel_writer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_color     (pix_color),
    .pix_sof       (pix_sof),
    .x             (x),
    .y             (y),
    .color         (color),
    .wr_en         (wr_en),
    .swapBuffer    (swapBuffer),
    .bufferSwapped (bufferSwapped),
    .frame_done    (frame_done),
    .sync_err      (sync_err),
    .frame_count   (frame_count)
  );

  typedef struct {
    int x;
    int y;
    int c;
    bit err;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         errors = 0, checks = 0;
  int         wr_count = 0, swap_cycles = 0, fd_count = 0, se_count = 0;
  int         last_x = -1, last_y = -1;
  int         mx = 0, my = 0;
  logic [7:0] exp_fc = 8'd0;
  bit         auto_ack = 1'b1, manual_ack = 1'b0;
  int         swap_cnt = 0;

  // Display model: acks 3 cycles after swapBuffer rises, or follows manual_ack.
  always @(negedge clk) begin
    if (swapBuffer === 1'b1) swap_cnt++;
    else swap_cnt = 0;
    bufferSwapped = auto_ack ? (swap_cnt == 3) : manual_ack;
  end

  // Write monitor: every strobe is checked against the oldest expected write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected got (%0d,%0d) c=%0d want no write", x, y, color);
      end else begin
        mon_e = exp_q.pop_front();
        if ({x, y, color, sync_err} !== {8'(mon_e.x), 8'(mon_e.y), 2'(mon_e.c), mon_e.err}) begin
          errors++;
          $display("FAIL write got (%0d,%0d) c=%0d err=%0d want (%0d,%0d) c=%0d err=%0d",
                   x, y, color, sync_err, mon_e.x, mon_e.y, mon_e.c, mon_e.err);
        end
      end
      last_x = int'(x);
      last_y = int'(y);
      if (sync_err === 1'b1) se_count++;
    end else if (sync_err === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL sync_err_no_write got sync_err=1 want 0");
    end
    if (swapBuffer === 1'b1) swap_cycles++;
    if (frame_done === 1'b1) fd_count++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference model: position of the next write, with SOF resync.
  task automatic accept(input logic [1:0] c, input logic sof);
    exp_t e;
    e.x = mx; e.y = my; e.c = int'(c); e.err = 1'b0;
    if (sof && (mx != 0 || my != 0)) begin
      e.x = 0; e.y = 0; e.err = 1'b1;
    end
    exp_q.push_back(e);
    if (e.x == W - 1) begin
      mx = 0;
      my = (e.y == H - 1) ? 0 : e.y + 1;
    end else begin
      mx = e.x + 1;
      my = e.y;
    end
  endtask

  task automatic send_px(input logic [1:0] c, input logic sof, input int gap_pct);
    int n = 0;
    @(negedge clk);
    if ($urandom_range(0, 99) < gap_pct) @(negedge clk);
    pix_valid = 1'b1; pix_color = c; pix_sof = sof;
    while (pix_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (pix_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout got pix_ready=%0b want 1 within 200 cycles", pix_ready);
      pix_valid = 1'b0;
      return;
    end
    accept(c, sof);
    @(posedge clk);
    #1 pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic send_frame(input int n, input int gap_pct, input logic sof_first);
    for (int i = 0; i < n; i++)
      send_px(2'($urandom_range(0, 3)), sof_first && (i == 0), gap_pct);
  endtask

  task automatic wait_fd(input int prev, input string tag);
    int k = 0;
    while (fd_count == prev && k < 400) begin step(); k++; end
    exp_fc = exp_fc + 8'd1;
    checks++;
    if (fd_count != prev + 1) begin
      errors++;
      $display("FAIL %s_frame_done got %0d pulses want 1", tag, fd_count - prev);
    end
    checks++;
    if (frame_count !== exp_fc) begin
      errors++;
      $display("FAIL %s_frame_count got %0d want %0d", tag, frame_count, exp_fc);
    end
    $display("frame %0d done (%s)", exp_fc, tag);
  endtask

  task automatic wait_swap(input string tag);
    int k = 0;
    while (swapBuffer !== 1'b1 && k < 400) begin step(); k++; end
    checks++;
    if (swapBuffer !== 1'b1) begin
      errors++;
      $display("FAIL %s_swap_req got swapBuffer=%0b want 1", tag, swapBuffer);
    end
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if ({x, y, color} !== 18'd0) begin
      errors++; $display("FAIL %s_xyc got (%0d,%0d,%0d) want (0,0,0)", tag, x, y, color);
    end
    checks++;
    if ({wr_en, swapBuffer, frame_done, sync_err} !== 4'b0000) begin
      errors++; $display("FAIL %s_strobes got %b want 0000", tag, {wr_en, swapBuffer, frame_done, sync_err});
    end
    checks++;
    if (frame_count !== 8'd0) begin
      errors++; $display("FAIL %s_frame_count got %0d want 0", tag, frame_count);
    end
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++; $display("FAIL %s_pix_ready got %0b want 1", tag, pix_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset");
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_full_frame();
    int wr0 = wr_count, sw0 = swap_cycles, fd0 = fd_count;
    auto_ack = 1'b1;
    send_frame(N, 0, 1'b1);
    wait_fd(fd0, "full_frame");
    repeat (3) step();
    checks++;
    if (wr_count - wr0 != N) begin
      errors++; $display("FAIL full_frame_writes got %0d want %0d", wr_count - wr0, N);
    end
    checks++;
    if (last_x != W - 1 || last_y != H - 1) begin
      errors++; $display("FAIL full_frame_last got (%0d,%0d) want (%0d,%0d)", last_x, last_y, W - 1, H - 1);
    end
    checks++;
    if (swap_cycles - sw0 != 3) begin
      errors++; $display("FAIL full_frame_swap_len got %0d want 3", swap_cycles - sw0);
    end
  endtask

  task automatic test_ack_stall();
    int wr0, fd0, acc = 0;
    logic [1:0] c;
    auto_ack = 1'b0; manual_ack = 1'b0;
    send_frame(N, 0, 1'b1);
    wait_swap("stall");
    wr0 = wr_count;
    c = 2'($urandom_range(0, 3));
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      pix_valid = 1'b1; pix_color = c; pix_sof = 1'b0;
      if (pix_ready === 1'b1) begin
        accept(c, 1'b0); acc++;
        c = 2'($urandom_range(0, 3));
      end
    end
    @(negedge clk) pix_valid = 1'b0;
    #1;
    checks++;
    if (acc != D) begin errors++; $display("FAIL stall_accepts got %0d want %0d", acc, D); end
    checks++;
    if (wr_count != wr0) begin errors++; $display("FAIL stall_writes got %0d want 0", wr_count - wr0); end
    checks++;
    if (pix_ready !== 1'b0) begin errors++; $display("FAIL stall_pix_ready got %0b want 0", pix_ready); end
    fd0 = fd_count;
    manual_ack = 1'b1; step(); manual_ack = 1'b0;
    wait_fd(fd0, "stall");
    repeat (8) step();
    checks++;
    if (wr_count - wr0 != D || exp_q.size() != 0) begin
      errors++; $display("FAIL stall_drain got %0d writes, %0d pending want %0d, 0", wr_count - wr0, exp_q.size(), D);
    end
    auto_ack = 1'b1;
    fd0 = fd_count;
    send_frame(N - D, 0, 1'b0);
    wait_fd(fd0, "stall_rest");
  endtask

  task automatic test_sof_resync();
    int se0 = se_count, fd0 = fd_count;
    auto_ack = 1'b1;
    send_frame(30, 0, 1'b1);
    send_px(2'($urandom_range(0, 3)), 1'b1, 0);
    send_frame(N - 1, 0, 1'b0);
    wait_fd(fd0, "resync");
    repeat (3) step();
    checks++;
    if (se_count - se0 != 1) begin errors++; $display("FAIL resync_sync_err got %0d want 1", se_count - se0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL resync_pending got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_ack_hold();
    int fd0;
    bit sw_bad = 1'b0;
    auto_ack = 1'b0; manual_ack = 1'b0;
    send_frame(N, 0, 1'b1);
    wait_swap("hold");
    fd0 = fd_count;
    manual_ack = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      if (swapBuffer !== 1'b0) sw_bad = 1'b1;
    end
    manual_ack = 1'b0;
    step();
    exp_fc = exp_fc + 8'd1;
    checks++;
    if (sw_bad) begin errors++; $display("FAIL hold_swap_low got swapBuffer=1 want 0 after ack"); end
    checks++;
    if (fd_count - fd0 != 1) begin errors++; $display("FAIL hold_frame_done got %0d want 1", fd_count - fd0); end
    checks++;
    if (frame_count !== exp_fc) begin errors++; $display("FAIL hold_frame_count got %0d want %0d", frame_count, exp_fc); end
    auto_ack = 1'b1;
  endtask

  task automatic test_reset_mid();
    int fd0;
    auto_ack = 1'b1;
    send_frame(2 * W + 38, 0, 1'b1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete(); mx = 0; my = 0; exp_fc = 8'd0;
    check_reset_state("reset_mid");
    @(negedge clk) reset = 1'b0;
    send_px(2'd3, 1'b1, 0);
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0 || last_x != 0 || last_y != 0) begin
      errors++; $display("FAIL reset_mid_first got (%0d,%0d) pending=%0d want (0,0) pending=0", last_x, last_y, exp_q.size());
    end
    fd0 = fd_count;
    send_frame(N - 1, 0, 1'b0);
    wait_fd(fd0, "reset_mid");
  endtask

  task automatic test_wrap_random();
    auto_ack = 1'b1;
    for (int f = 0; f < 253; f++) begin
      int fd0 = fd_count;
      send_frame(N, 0, 1'b1);
      wait_fd(fd0, "preroll");
    end
    for (int f = 0; f < 3; f++) begin
      int fd0 = fd_count;
      send_frame(N, 50, 1'b1);
      wait_fd(fd0, "wrap");
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_ack_stall();
    test_sof_resync();
    test_ack_hold();
    test_reset_mid();
    test_wrap_random();
    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
